// File: rtl/rtlinf_read_sequencer_pkg.sv
// Shared RTLinf definitions: sequencer FSM states,
// memory read latency and default widths.
package rtlinf_read_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } seq_state_e;

  localparam int MEM_READ_LATENCY = 1;

  localparam int DEF_LOG_MAX_ITERS          = 8;
  localparam int DEF_LOG_MAX_READS_PER_ITER = 8;
  localparam int DEF_LOG_MAX_ADDRESS        = 12;
  localparam int DEF_DATA_WIDTH             = 32;
  localparam int DEF_CREDITS                = 4;

endpackage

// File: rtl/rtlinf_read_sequencer_if.sv
// Sequencer bus: MEM read port plus downstream data path.
// master = sequencer side, slave = MEM/downstream side.
interface rtlinf_read_sequencer_if #(
  parameter int AW = 12,
  parameter int DW = 32
);

  logic          mem_read;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_valid;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_pop;

  modport master (
    output mem_read,
    output mem_addr,
    input  mem_data,
    input  mem_valid,
    output out_data,
    output out_valid,
    output out_last,
    input  out_pop
  );

  modport slave (
    input  mem_read,
    input  mem_addr,
    output mem_data,
    output mem_valid,
    input  out_data,
    input  out_valid,
    input  out_last,
    output out_pop
  );

endinterface

// File: rtl/rtlinf_credit_counter.sv
// Credit counter mirroring free downstream slots.
// Ports: clk, rst, take (-1), give (+1), avail, count.
module rtlinf_credit_counter #(
  parameter int CREDITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         take,
  input  logic                         give,
  output logic                         avail,
  output logic [$clog2(CREDITS+1)-1:0] count
);

  localparam int CW = $clog2(CREDITS + 1);

  // take never arrives at zero; give at full saturates
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CW'(CREDITS);
    end else if (take && !give) begin
      if (count != '0)
        count <= count - CW'(1);
    end else if (give && !take) begin
      if (count != CW'(CREDITS))
        count <= count + CW'(1);
    end
  end

  assign avail = (count != '0);

endmodule

// File: rtl/rtlinf_read_sequencer.sv
// Read sequencer for one RTLinf MEM port.
// Ports: clk, rst, configure + job fields, busy, done, bus (master).
module rtlinf_read_sequencer
  import rtlinf_read_sequencer_pkg::*;
#(
  parameter int LOG_MAX_ITERS          = DEF_LOG_MAX_ITERS,
  parameter int LOG_MAX_READS_PER_ITER = DEF_LOG_MAX_READS_PER_ITER,
  parameter int LOG_MAX_ADDRESS        = DEF_LOG_MAX_ADDRESS,
  parameter int DATA_WIDTH             = DEF_DATA_WIDTH,
  parameter int CREDITS                = DEF_CREDITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  input  logic [LOG_MAX_ADDRESS-1:0]        read_address,
  input  logic                              addr_restart,
  output logic                              busy,
  output logic                              done,
  rtlinf_read_sequencer_if.master           bus
);

  localparam int LI = LOG_MAX_ITERS;
  localparam int LR = LOG_MAX_READS_PER_ITER;
  localparam int LA = LOG_MAX_ADDRESS;
  localparam int CW = $clog2(CREDITS + 1);
  localparam int OW = $clog2(CREDITS + MEM_READ_LATENCY + 1);

  seq_state_e    state;
  logic [LI-1:0] nit;
  logic [LI-1:0] it_cnt;
  logic [LR-1:0] nrd;
  logic [LR-1:0] rd_cnt;
  logic [LA-1:0] base;
  logic [LA-1:0] offs;
  logic          restart;
  logic [OW-1:0] outst;
  logic [OW-1:0] outst_nxt;
  logic          last_q;
  logic          drop_q;
  logic          issue;
  logic          ret;
  logic          rd_end;
  logic          it_end;
  logic          credit_ok;
  logic [CW-1:0] credits;
  logic          unused_credits;

  rtlinf_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credits (
    .clk   (clk),
    .rst   (rst),
    .take  (issue),
    .give  (bus.out_pop),
    .avail (credit_ok),
    .count (credits)
  );

  assign unused_credits = ^credits;

  assign issue  = (state == S_RUN) && credit_ok;
  assign rd_end = (rd_cnt == nrd - LR'(1));
  assign it_end = (it_cnt == nit - LI'(1));

  // a response in the cycle after reset belongs to the aborted job
  assign ret = bus.mem_valid && !drop_q;

  assign bus.mem_read = issue;
  assign bus.mem_addr = base + offs;

  always_comb begin
    outst_nxt = outst;
    if (issue && !ret)
      outst_nxt = outst + OW'(1);
    else if (!issue && ret && outst != '0)
      outst_nxt = outst - OW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      nit           <= '0;
      nrd           <= '0;
      base          <= '0;
      restart       <= 1'b0;
      it_cnt        <= '0;
      rd_cnt        <= '0;
      offs          <= '0;
      outst         <= '0;
      last_q        <= 1'b0;
      drop_q        <= 1'b1;
      bus.out_data  <= '0;
      bus.out_valid <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      done          <= 1'b0;
      drop_q        <= 1'b0;
      outst         <= outst_nxt;
      // tag rides one stage behind the read
      last_q        <= issue && rd_end;
      bus.out_valid <= ret;
      bus.out_last  <= ret && last_q;
      if (ret)
        bus.out_data <= bus.mem_data;

      unique case (state)
        S_IDLE: begin
          busy <= configure;
          if (configure) begin
            nit     <= num_iters;
            nrd     <= num_reads_per_iter;
            base    <= read_address;
            restart <= addr_restart;
            it_cnt  <= '0;
            rd_cnt  <= '0;
            offs    <= '0;
            if (num_iters == '0 ||
                num_reads_per_iter == '0)
              state <= S_DONE;
            else
              state <= S_RUN;
          end
        end
        S_RUN: begin
          if (issue) begin
            if (rd_end && restart)
              offs <= '0;
            else
              offs <= offs + LA'(1);
            if (rd_end) begin
              rd_cnt <= '0;
              it_cnt <= it_cnt + LI'(1);
              if (it_end)
                state <= S_DRAIN;
            end else begin
              rd_cnt <= rd_cnt + LR'(1);
            end
          end
        end
        S_DRAIN: begin
          if (outst_nxt == '0)
            state <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rtlinf_read_sequencer.sv
// Self-checking bench for rtlinf_read_sequencer with
// a MEM model, randomized downstream pops and a job model.
module tb_rtlinf_read_sequencer;

  localparam int LI = 8;
  localparam int LR = 8;
  localparam int LA = 12;
  localparam int DW = 32;
  localparam int CR = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          configure;
  logic [LI-1:0] num_iters;
  logic [LR-1:0] num_reads_per_iter;
  logic [LA-1:0] read_address;
  logic          addr_restart;
  logic          busy;
  logic          done;

  rtlinf_read_sequencer_if #(.AW(LA), .DW(DW)) bus ();

  rtlinf_read_sequencer #(
    .LOG_MAX_ITERS          (LI),
    .LOG_MAX_READS_PER_ITER (LR),
    .LOG_MAX_ADDRESS        (LA),
    .DATA_WIDTH             (DW),
    .CREDITS                (CR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .configure          (configure),
    .num_iters          (num_iters),
    .num_reads_per_iter (num_reads_per_iter),
    .read_address       (read_address),
    .addr_restart       (addr_restart),
    .busy               (busy),
    .done               (done),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [DW-1:0] mem_word(input logic [LA-1:0] a);
    return 32'h5A00_0000 ^ ({20'd0, a} * 32'd40503);
  endfunction

  // MEM: fixed one-cycle read latency
  always @(posedge clk) begin
    bus.mem_valid <= bus.mem_read;
    bus.mem_data  <= mem_word(bus.mem_addr);
  end

  int q_cyc[$];
  int q_cred[$];
  int j_dones;

  task automatic do_reset();
    rst = 1'b1;
    configure = 1'b0;
    bus.out_pop = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One job; the model predicts every cycle's mem_read from
  // credits = CR - issued + pops (pops of earlier cycles).
  task automatic run_job(input int nit, input int nrd,
                         input int base, input bit rs,
                         input int prob, input int hold,
                         input int gap, input int repulse,
                         input string nm);
    logic [LA-1:0] ea[$];
    bit el[$];
    int total, issued, recv, pops, held;
    int last_out, done_cyc, cyc;
    bit fin, pop, exp_rd, exp_busy;
    for (int i = 0; i < nit; i++)
      for (int j = 0; j < nrd; j++) begin
        ea.push_back(LA'(rs ? base + j : base + i * nrd + j));
        el.push_back(j == nrd - 1);
      end
    total = nit * nrd;
    issued = 0; recv = 0; pops = 0;
    last_out = -10; done_cyc = -1; fin = 0;
    j_dones = 0;
    q_cyc.delete();
    q_cred.delete();
    num_iters = LI'(nit);
    num_reads_per_iter = LR'(nrd);
    read_address = LA'(base);
    addr_restart = rs;
    configure = 1'b1;
    bus.out_pop = 1'b0;
    for (cyc = 0; cyc < 500 && !fin; cyc++) begin
      @(negedge clk);
      configure = (cyc == repulse);
      if (cyc == repulse) begin
        num_iters = '0;
        read_address = '1;
        addr_restart = ~rs;
      end
      exp_rd = (issued < total) && (CR - issued + pops > 0);
      n_cmp++;
      if (bus.mem_read !== exp_rd)
        $display("FAIL %s mem_read c%0d: got %b want %b",
                 nm, cyc, bus.mem_read, exp_rd);
      if (bus.mem_read !== exp_rd) n_bad++;
      if (bus.mem_read === 1'b1 && issued < total) begin
        n_cmp++;
        if (bus.mem_addr !== ea[issued]) begin
          n_bad++;
          $display("FAIL %s mem_addr #%0d: got %0d want %0d",
                   nm, issued, bus.mem_addr, ea[issued]);
        end
        q_cyc.push_back(cyc);
        q_cred.push_back(int'(dut.credits));
        issued++;
      end
      if (bus.out_valid === 1'b1) begin
        n_cmp++;
        if (recv >= total) begin
          n_bad++;
          $display("FAIL %s extra out: got %0d words want %0d",
                   nm, recv + 1, total);
        end else if (bus.out_data !== mem_word(ea[recv]) ||
                     bus.out_last !== el[recv]) begin
          n_bad++;
          $display("FAIL %s out #%0d: got %h/%b want %h/%b",
                   nm, recv, bus.out_data, bus.out_last,
                   mem_word(ea[recv]), el[recv]);
        end
        recv++;
        last_out = cyc;
      end
      exp_busy = !(done_cyc >= 0 && cyc > done_cyc);
      n_cmp++;
      if (busy !== exp_busy) begin
        n_bad++;
        $display("FAIL %s busy c%0d: got %b want %b",
                 nm, cyc, busy, exp_busy);
      end
      if (done === 1'b1) begin
        j_dones++;
        done_cyc = cyc;
        n_cmp++;
        if (recv != total || cyc != last_out + 1) begin
          n_bad++;
          $display("FAIL %s done: got c%0d/%0d words want c%0d/%0d",
                   nm, cyc, recv, last_out + 1, total);
        end
      end
      held = recv - pops;
      if (done_cyc >= 0 && cyc > done_cyc && held == 0)
        fin = 1;
      pop = 0;
      if (held > 0) begin
        if (cyc < hold) pop = 0;
        else if (cyc == hold) pop = 1;
        else if (cyc <= hold + gap) pop = 0;
        else pop = ($urandom_range(99) < prob);
      end
      bus.out_pop = pop;
      if (pop) pops++;
    end
    n_cmp++;
    if (!fin || j_dones != 1) begin
      n_bad++;
      $display("FAIL %s end: got fin=%b dones=%0d want 1/1",
               nm, fin, j_dones);
      if (!fin) do_reset();
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_cmp++;
      if (bus.mem_read !== 1'b0 || bus.mem_addr !== '0 ||
          bus.out_data !== '0 || bus.out_valid !== 1'b0 ||
          bus.out_last !== 1'b0 || busy !== 1'b0 ||
          done !== 1'b0 || dut.credits !== 3'(CR)) begin
        n_bad++;
        $display("FAIL reset%0d: got rd=%b a=%0d d=%h v=%b l=%b b=%b dn=%b cr=%0d want zeros cr=%0d",
                 k, bus.mem_read, bus.mem_addr, bus.out_data,
                 bus.out_valid, bus.out_last, busy, done,
                 dut.credits, CR);
      end
      rst = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_restart_seq();
    run_job(2, 4, 0, 1'b1, 100, 0, 0, -1, "restart");
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (i >= q_cyc.size() || q_cyc[i] != i) begin
        n_bad++;
        $display("FAIL restart dense #%0d: got c%0d want c%0d",
                 i, (i < q_cyc.size()) ? q_cyc[i] : -1, i);
      end
    end
  endtask

  task automatic test_wrap();
    run_job(2, 2, 4094, 1'b0, 100, 0, 0, -1, "wrap");
  endtask

  task automatic test_credit_stall();
    int early, mid, mid_cyc;
    run_job(1, 8, 20, 1'b1, 100, 10, 3, -1, "stall");
    early = 0; mid = 0; mid_cyc = -1;
    foreach (q_cyc[i]) begin
      if (q_cyc[i] <= 9) early++;
      else if (q_cyc[i] <= 13) begin
        mid++;
        mid_cyc = q_cyc[i];
      end
    end
    n_cmp++;
    if (early != 4 || mid != 1 || mid_cyc != 11) begin
      n_bad++;
      $display("FAIL stall: got %0d/%0d@c%0d want 4/1@c11",
               early, mid, mid_cyc);
    end
  endtask

  task automatic test_credit_one();
    run_job(1, 12, 300, 1'b1, 100, 6, 0, -1, "cred1");
    n_cmp++;
    if (q_cyc.size() != 12 || q_cyc[4] != 7) begin
      n_bad++;
      $display("FAIL cred1 resume: got %0d issues want 12 from c7",
               q_cyc.size());
    end else begin
      for (int i = 4; i < 12; i++) begin
        n_cmp++;
        if (q_cred[i] != 1 || (i > 4 && q_cyc[i] != q_cyc[i-1] + 1)) begin
          n_bad++;
          $display("FAIL cred1 #%0d: got cr=%0d c%0d want cr=1 c%0d",
                   i, q_cred[i], q_cyc[i], q_cyc[i-1] + 1);
        end
      end
    end
  endtask

  task automatic test_zero_count(input int nit, input int nrd,
                                 input string nm);
    bus.out_pop = 1'b0;
    num_iters = LI'(nit);
    num_reads_per_iter = LR'(nrd);
    read_address = 12'd77;
    addr_restart = 1'b1;
    configure = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      configure = 1'b0;
      n_cmp++;
      if (busy !== (c < 2) || done !== (c == 1) ||
          bus.mem_read !== 1'b0) begin
        n_bad++;
        $display("FAIL %s c%0d: got b=%b d=%b rd=%b want b=%b d=%b rd=0",
                 nm, c, busy, done, bus.mem_read, c < 2, c == 1);
      end
    end
  endtask

  task automatic test_configure_ignored();
    run_job(2, 3, 50, 1'b0, 100, 0, 0, 1, "repulse");
  endtask

  task automatic test_rst_mid_run();
    bus.out_pop = 1'b0;
    num_iters = 8'd3;
    num_reads_per_iter = 8'd5;
    read_address = 12'd100;
    addr_restart = 1'b1;
    configure = 1'b1;
    @(negedge clk);
    configure = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (bus.mem_read !== 1'b0 || bus.mem_addr !== '0 ||
        bus.out_data !== '0 || bus.out_valid !== 1'b0 ||
        bus.out_last !== 1'b0 || busy !== 1'b0 ||
        done !== 1'b0 || dut.credits !== 3'(CR)) begin
      n_bad++;
      $display("FAIL midrst: got rd=%b a=%0d v=%b b=%b cr=%0d want zeros cr=%0d",
               bus.mem_read, bus.mem_addr, bus.out_valid, busy,
               dut.credits, CR);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL late_valid: got %b want 0", bus.out_valid);
    end
    run_job(3, 5, 100, 1'b1, 100, 0, 0, -1, "after_rst");
  endtask

  task automatic test_back_to_back();
    run_job(1, 3, 9, 1'b0, 100, 0, 0, -1, "b2b_a");
    run_job(2, 2, 600, 1'b1, 100, 0, 0, -1, "b2b_b");
  endtask

  task automatic test_random();
    int nit, nrd, base, prob, rp;
    bit rs;
    for (int k = 0; k < 8; k++) begin
      nit  = $urandom_range(4, 1);
      nrd  = $urandom_range(6, 1);
      base = $urandom_range(4095);
      rs   = 1'($urandom_range(1));
      prob = $urandom_range(100, 30);
      rp   = (nit * nrd >= 2 && $urandom_range(1) == 1) ? 1 : -1;
      run_job(nit, nrd, base, rs, prob, 0, 0, rp, "random");
    end
  endtask

  initial begin
    rst = 1'b1;
    configure = 1'b0;
    num_iters = '0;
    num_reads_per_iter = '0;
    read_address = '0;
    addr_restart = 1'b0;
    bus.out_pop = 1'b0;
    test_reset();
    test_restart_seq();
    test_wrap();
    test_credit_stall();
    test_credit_one();
    test_zero_count(0, 4, "zero_iters");
    test_zero_count(3, 0, "zero_reads");
    test_configure_ignored();
    test_rst_mid_run();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rtlinf_read_sequencer.md
# rtlinf_read_sequencer

Sequencer that drives one read port of an RTLinf `MEM` (activation or weight memory) on behalf of the RTLinf datapath. A `configure` pulse starts a job of `num_iters` × `num_reads_per_iter` reads from a base address. The block issues at most one read per cycle, throttled by a credit count that mirrors free slots in the downstream buffer. It returns the memory data with a registered valid and an end-of-iteration tag, and pulses `done` once every issued read has returned.

## Interface
- `LOG_MAX_ITERS`, 8, width of the iteration count
- `LOG_MAX_READS_PER_ITER`, 8, width of the reads-per-iteration count
- `LOG_MAX_ADDRESS`, 12, memory address width
- `DATA_WIDTH`, 32, memory word width (`GROUP_SIZE*DATA_WIDTH` for activations)
- `CREDITS`, 4, downstream buffer depth; must be ≥1
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `configure` in 1: start pulse; sampled only in IDLE
- `num_iters` in `LOG_MAX_ITERS`: number of iterations
- `num_reads_per_iter` in `LOG_MAX_READS_PER_ITER`: reads per iteration
- `read_address` in `LOG_MAX_ADDRESS`: base address
- `addr_restart` in 1: 1 = every iteration rereads the same window; 0 = address runs continuously
- `mem_read` out 1: read strobe to `MEM`
- `mem_addr` out `LOG_MAX_ADDRESS`: read address to `MEM`
- `mem_data` in `DATA_WIDTH`: `MEM` read data
- `mem_valid` in 1: `MEM` valid; fixed 1-cycle latency after `mem_read`
- `out_data` out `DATA_WIDTH`: registered data to downstream
- `out_valid` out 1: `out_data` valid
- `out_last` out 1: word is the last read of an iteration
- `out_pop` in 1: downstream freed one slot; returns one credit
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at job end

## Operation
- States:
  - IDLE: waits for `configure`.
  - RUN: issues reads.
  - DRAIN: all reads issued; waits for outstanding reads to return.
  - DONE: asserts `done` for one cycle, then goes to IDLE.
- IDLE with `configure`=1:
  - Latch `num_iters`, `num_reads_per_iter`, `read_address`, `addr_restart`.
  - If either count is 0, go to DONE and issue no reads; otherwise go to RUN.
- `configure` in any state other than IDLE is ignored.
- RUN issue rule: `mem_read`=1 exactly when state=RUN and credits>0.
- On each issue:
  - Read-in-iteration counter increments.
  - At `num_reads_per_iter-1` it clears to 0 and the iteration counter increments.
  - The issue after the last read of the last iteration moves the state to DRAIN.
- Addressing, modulo 2^`LOG_MAX_ADDRESS` (wraps silently):
  - `addr_restart`=1: `mem_addr` = base + read index within the iteration.
  - `addr_restart`=0: `mem_addr` = base + total read index.
- Credits:
  - Reset value is `CREDITS`.
  - Issue only: −1. `out_pop` only: +1. Both in the same cycle: unchanged.
  - `out_pop` at credits=`CREDITS` is a protocol error; the count saturates.
- Outstanding counter: +1 on issue, −1 on `mem_valid`, unchanged on both. DRAIN moves to DONE when it is 0.
- Tag path: the last-of-iteration flag is registered at issue so it aligns with `mem_valid`, then registered again into `out_last`.
- `mem_valid` with no outstanding read is an error; data is still forwarded.

## Timing
- Reset values: `mem_read`=0, `mem_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0; credits=`CREDITS`; outstanding=0; state=IDLE.
- `rst` mid-job aborts the job immediately; late `mem_valid` after the reset is dropped.
- `configure` high at edge t gives `busy`=1 and the first `mem_read` in cycle t+1 (given credits).
- Data latency: `mem_read` in cycle k → `mem_valid` in k+1 → `out_valid`/`out_data`/`out_last` in k+2.
- Throughput is one read per cycle while credits are available. A pop in cycle k allows an issue in cycle k+1.
- `done` is high in the cycle after outstanding reaches 0; `busy` drops the cycle after `done`.
- Zero-count job: `done` in t+2; `mem_read` never asserts.
- A new `configure` is accepted in the first IDLE cycle after `done`.

## Structure
- Shared RTLinf package/header holds:
  - FSM state encodings (IDLE/RUN/DRAIN/DONE).
  - `MEM_READ_LATENCY`=1.
  - Default widths shared with the other RTLinf modules.
- Sub-module `rtlinf_credit_counter`:
  - Parameter `CREDITS`; inputs `take`/`give`; outputs `avail` and count.
  - Count width is $clog2(CREDITS+1).
  - Reused later by the distribute and write-back paths.
- Everything else stays in one module of about 200 lines.

## Test plan
- iters=2, reads=4, base=0, restart=1, CREDITS=4, `out_pop` every output cycle → `mem_addr` 0,1,2,3,0,1,2,3 on 8 consecutive cycles from t+1; `out_last` on outputs 4 and 8; exactly one `done`.
- restart=0, base=4094, iters=2, reads=2 → addresses 4094,4095,0,1; `out_last` on outputs 2 and 4.
- CREDITS=4, iters=1, reads=8, no `out_pop` → exactly 4 reads, then `mem_read`=0 held; one pop → exactly one more read in the next cycle.
- iters=0 (and separately reads=0) → `done` at t+2, no `mem_read`, `busy` high for 2 cycles only.
- `configure` re-pulsed during RUN → ignored, address sequence unchanged; `rst` mid-RUN → next cycle all outputs 0, credits=`CREDITS`, new job restarts from base.
- credits=1 with issue and `out_pop` in the same cycle → credits stay 1 and issue continues every cycle with no bubble.
